// File: rtl/nvdla_wr_req_arb.sv
// Round-robin write-request arbiter: N DMA clients share one MCIF write port.
// Grant is held for a whole cmd+data burst; ack owners are queued in order
// so MCIF write-complete pulses route back to the issuing client.
// Ports: cli_wr_req_* (per-client valid/ready/pd), mcif_wr_req_* (merged),
// mcif_wr_rsp_complete in, cli_wr_rsp_complete out, status/error flags.
module nvdla_wr_req_arb #(
  parameter int NUM_CLIENTS = 3,
  parameter int PD_W        = 66,
  parameter int SIZE_W      = 13,
  parameter int ACK_DEPTH   = 16,
  parameter int ACK_AW      = 4
) (
  input  logic                        nvdla_core_clk,
  input  logic                        nvdla_core_rst,
  input  logic [NUM_CLIENTS-1:0]      cli_wr_req_valid,
  output logic [NUM_CLIENTS-1:0]      cli_wr_req_ready,
  input  logic [NUM_CLIENTS*PD_W-1:0] cli_wr_req_pd,
  output logic                        mcif_wr_req_valid,
  input  logic                        mcif_wr_req_ready,
  output logic [PD_W-1:0]             mcif_wr_req_pd,
  output logic [1:0]                  mcif_wr_req_id,
  input  logic                        mcif_wr_rsp_complete,
  output logic [NUM_CLIENTS-1:0]      cli_wr_rsp_complete,
  output logic [ACK_AW:0]             ack_fifo_cnt,
  output logic                        arb_busy,
  output logic                        err_unexp_cpl,
  output logic                        err_proto
);

  localparam int NC = NUM_CLIENTS;
  localparam logic [SIZE_W-1:0] BEAT_ONE = 1;
  localparam logic [ACK_AW-1:0] PTR_ONE  = 1;
  localparam logic [ACK_AW:0]   CNT_ONE  = 1;
  localparam logic [ACK_AW:0]   CNT_FULL = (ACK_AW+1)'(ACK_DEPTH);
  localparam logic [NC-1:0]     ONE_HOT0 = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    BURST = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          owner_q, owner_d;
  logic [1:0]          ptr_q, ptr_d;
  logic [SIZE_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [ACK_AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ACK_AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ACK_AW:0]     cnt_q, cnt_d;
  logic                err_unexp_q, err_unexp_d;
  logic                err_proto_q, err_proto_d;
  logic [1:0]          ack_mem_q [ACK_DEPTH];

  // Clients padded out to four slots so a 2-bit id indexes safely.
  logic [PD_W-1:0]     pd_arr [4];
  logic [3:0]          valid4;
  logic [3:0]          elig4;
  logic [3:0]          data4;
  logic                fifo_full;
  logic                fifo_empty;

  assign fifo_full  = (cnt_q == CNT_FULL);
  assign fifo_empty = (cnt_q == '0);

  for (genvar g = 0; g < 4; g++) begin : g_slot
    if (g < NC) begin : g_on
      assign pd_arr[g] = cli_wr_req_pd[g*PD_W +: PD_W];
      assign valid4[g] = cli_wr_req_valid[g];
    end else begin : g_off
      assign pd_arr[g] = '0;
      assign valid4[g] = 1'b0;
    end
    // Ack cmds are held back while there is nowhere to record the owner.
    assign elig4[g] = valid4[g] & pd_arr[g][PD_W-1] &
                      ~(pd_arr[g][SIZE_W] & fifo_full);
    assign data4[g] = valid4[g] & ~pd_arr[g][PD_W-1];
  end

  logic       win_vld;
  logic [1:0] win_id;
  logic [2:0] cand;

  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    cand    = '0;
    for (int k = 0; k < NC; k++) begin
      cand = {1'b0, ptr_q} + 3'(k);
      if (cand >= 3'(NC)) cand = cand - 3'(NC);
      if (!win_vld && elig4[cand[1:0]]) begin
        win_vld = 1'b1;
        win_id  = cand[1:0];
      end
    end
  end

  logic            grant_vld;
  logic [1:0]      grant_id;
  logic            cur_valid;
  logic [PD_W-1:0] cur_pd;
  logic            hs;
  logic            cmd_acc;
  logic            data_acc;
  logic            push;
  logic            pop;
  logic [2:0]      nxt_ptr;
  logic [1:0]      head_id;

  always_comb begin
    if (state_q == IDLE) begin
      grant_vld = win_vld;
      grant_id  = win_id;
    end else begin
      grant_vld = 1'b1;
      grant_id  = owner_q;
    end
  end

  assign cur_valid = grant_vld & valid4[grant_id];
  assign cur_pd    = grant_vld ? pd_arr[grant_id] : '0;
  assign hs        = cur_valid & mcif_wr_req_ready;
  // Cmds from the owner mid-burst pass through but are not counted.
  assign cmd_acc   = hs & cur_pd[PD_W-1] & (state_q != BURST);
  assign data_acc  = hs & ~cur_pd[PD_W-1] & (state_q == BURST);
  assign push      = cmd_acc & cur_pd[SIZE_W];
  // Pop only against entries present at cycle start.
  assign pop       = mcif_wr_rsp_complete & ~fifo_empty;
  assign head_id   = ack_mem_q[rd_ptr_q];
  assign nxt_ptr   = {1'b0, grant_id} + 3'd1;

  assign mcif_wr_req_valid = cur_valid;
  assign mcif_wr_req_pd    = cur_pd;
  assign mcif_wr_req_id    = grant_vld ? grant_id : 2'd0;
  assign cli_wr_req_ready  = (grant_vld & mcif_wr_req_ready) ?
                             (ONE_HOT0 << grant_id) : '0;
  assign cli_wr_rsp_complete = pop ? (ONE_HOT0 << head_id) : '0;
  assign ack_fifo_cnt      = cnt_q;
  assign arb_busy          = (state_q != IDLE);
  assign err_unexp_cpl     = err_unexp_q;
  assign err_proto         = err_proto_q;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    beat_cnt_d = beat_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (win_vld) begin
          owner_d = win_id;
          state_d = cmd_acc ? BURST : HOLD;
        end
      end
      HOLD: begin
        if (cmd_acc) state_d = BURST;
      end
      BURST: begin
        if (data_acc) begin
          if (beat_cnt_q == '0) state_d = IDLE;
          else beat_cnt_d = beat_cnt_q - BEAT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (cmd_acc) begin
      beat_cnt_d = cur_pd[SIZE_W-1:0];
      ptr_d      = (nxt_ptr >= 3'(NC)) ? 2'd0 : nxt_ptr[1:0];
    end
  end

  always_comb begin
    wr_ptr_d    = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d    = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    cnt_d       = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
    err_unexp_d = err_unexp_q |
                  (mcif_wr_rsp_complete & fifo_empty);
    err_proto_d = err_proto_q |
                  ((state_q == IDLE) & (|data4));
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      ptr_q       <= '0;
      beat_cnt_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      err_unexp_q <= 1'b0;
      err_proto_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      ptr_q       <= ptr_d;
      beat_cnt_q  <= beat_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      err_unexp_q <= err_unexp_d;
      err_proto_q <= err_proto_d;
    end
  end

  // Owner storage needs no reset: occupancy gates every read.
  always_ff @(posedge nvdla_core_clk) begin
    if (push) ack_mem_q[wr_ptr_q] <= grant_id;
  end

endmodule
